execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  MIPS EX stage and EX/MEM pipeline register. Computes ALU result, zero flag, branch target and destination
//  register, then feeds the memory stage (WB, MEM, PCJump, ALUResult, ALUZero, RegB, RegF_wreg).
//  Contains an iterative 32-cycle MULT/DIV unit with HI/LO registers; stalls upstream while it is busy.
// PARAMETERS
//  MD_CYCLES  32  iteration count of the MULT/DIV unit (fixed, one bit per cycle)
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  rst           in   1   synchronous, active-high reset
//  inValid       in   1   ID/EX holds a real instruction
//  inWB          in   2   WB control, passed through
//  inMEM         in   3   MEM control {branch, read, write}, passed through
//  inALUCtl      in   4   operation code, see BEHAVIOUR
//  inALUSrc      in   1   1: operand B = inImm, 0: inRegB
//  inRegDst      in   1   1: dest = inRd, 0: inRt
//  inPC          in   32  PC+4 of the instruction
//  inRegA        in   32  rs value
//  inRegB        in   32  rt value
//  inImm         in   32  sign-extended immediate; shamt = inImm[10:6]
//  inRt, inRd    in   5   candidate destination registers
//  Debug_on      in   1   freeze: no state changes while high
//  outWB         out  2   registered WB control
//  outMEM        out  3   registered MEM control
//  outPCJump     out  32  registered inPC + (inImm<<2)
//  outALUResult  out  32  registered ALU result
//  outALUZero    out  1   registered (inRegA - opB) == 0
//  outRegB       out  32  registered inRegB (store data)
//  outRegF_wreg  out  5   registered destination register
//  outStall      out  1   combinational: MULT/DIV busy, upstream must hold ID/EX
// BEHAVIOUR
//  - ALUCtl: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB, 7 SLT (signed), 8 SLL, 9 SRL, A SRA (shift opB by shamt),
//    B LUI (opB<<16), C MULT, D DIV, E MFHI, F MFLO, 5 reserved -> result 0. All 32-bit, overflow wraps silently.
//  - Reset: all outputs 0, HI=LO=0, FSM IDLE, outStall=0. Reset mid-MULT/DIV aborts; HI/LO not updated.
//  - Latency 1: on each posedge with outStall=0 and Debug_on=0, the EX/MEM register loads the result of the ID/EX inputs.
//  - Bubble: inValid=0, or ALUCtl C/D, or outStall=1 -> outWB=00, outMEM=000, other outputs 0.
//  - FSM IDLE -> MUL (ALUCtl C) or DIV (ALUCtl D) on accept (inValid, outStall=0, Debug_on=0); operands latched.
//    Counter 0..31, one step per cycle. At the edge where count=31: HI/LO written, FSM -> IDLE.
//    outStall=1 for exactly 32 cycles after accept; the next instruction is taken on cycle 33.
//  - MULT: signed 32x32 -> 64; HI=upper, LO=lower. DIV: signed; LO=quotient, HI=remainder (sign of dividend).
//  - Divisor 0: still 32 cycles; LO=32'hFFFFFFFF, HI=dividend. -2^31 / -1: LO=32'h80000000, HI=0.
//  - MFHI/MFLO read HI/LO as written; never issued while busy (stall guarantees ordering).
//  - Debug_on=1: EX/MEM register, HI/LO, FSM and counter hold; outStall keeps its value.
//  - Debug_on and rst together: rst wins.
// CONFIGURATION
//  EXEC_MULDIV_EN defined: MULT/DIV unit, HI/LO and FSM built as above.
//  Not defined: ALUCtl C/D give a 1-cycle bubble and leave HI/LO unchanged (constant 0);
//   MFHI/MFLO return 0; outStall tied 0.
// TESTING
//  1 ADD A=5, B=7, RegDst=1, Rd=3 -> next cycle ALUResult=12, wreg=3, Zero=0, WB/MEM pass through.
//  2 SUB A=B=32'h1234, MEM=100, PC=0x40, Imm=2 -> Zero=1, PCJump=0x48.
//  3 MULT -3 x 7, then MFLO, MFHI -> stall high 32 cycles; MFLO=32'hFFFFFFEB, MFHI=32'hFFFFFFFF.
//  4 DIV 7 / 0 -> after 32 cycles LO=32'hFFFFFFFF, HI=7; DIV -7/2 -> LO=-3, HI=-1.
//  5 rst at cycle 10 of a MULT -> next cycle outStall=0, all outputs 0, MFLO returns 0.
//  6 Debug_on raised mid-DIV for 5 cycles -> total stall 37 cycles; results identical to the undisturbed run.

Source files
------------

// File: rtl/execute_stage.sv
// MIPS EX stage with EX/MEM pipeline register and an iterative signed MULT/DIV unit (HI/LO).
// The MULT/DIV unit is built only when EXEC_MULDIV_EN is defined; otherwise HI/LO read as 0 and no stall occurs.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    input  logic [1:0]  inWB,
    input  logic [2:0]  inMEM,
    input  logic [3:0]  inALUCtl,
    input  logic        inALUSrc,
    input  logic        inRegDst,
    input  logic [31:0] inPC,
    input  logic [31:0] inRegA,
    input  logic [31:0] inRegB,
    input  logic [31:0] inImm,
    input  logic [4:0]  inRt,
    input  logic [4:0]  inRd,
    input  logic        Debug_on,
    output logic [1:0]  outWB,
    output logic [2:0]  outMEM,
    output logic [31:0] outPCJump,
    output logic [31:0] outALUResult,
    output logic        outALUZero,
    output logic [31:0] outRegB,
    output logic [4:0]  outRegF_wreg,
    output logic        outStall
);
    logic [31:0] op_b, alu_res, diff, hi, lo;
    logic [4:0]  shamt;
    logic        is_md, bubble, stall;

    assign op_b   = inALUSrc ? inImm : inRegB;
    assign shamt  = inImm[10:6];
    assign diff   = inRegA - op_b;
    assign is_md  = (inALUCtl == 4'hC) || (inALUCtl == 4'hD);
    assign bubble = !inValid || is_md || stall;

    always_comb begin
        alu_res = '0;
        case (inALUCtl)
            4'h0: alu_res = inRegA & op_b;
            4'h1: alu_res = inRegA | op_b;
            4'h2: alu_res = inRegA + op_b;
            4'h3: alu_res = inRegA ^ op_b;
            4'h4: alu_res = ~(inRegA | op_b);
            4'h6: alu_res = diff;
            4'h7: alu_res = {31'b0, $signed(inRegA) < $signed(op_b)};
            4'h8: alu_res = op_b << shamt;
            4'h9: alu_res = op_b >> shamt;
            4'hA: alu_res = $signed(op_b) >>> shamt;
            4'hB: alu_res = {op_b[15:0], 16'b0};
            4'hE: alu_res = hi;
            4'hF: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (!Debug_on && bubble)) begin
            outWB        <= '0;
            outMEM       <= '0;
            outPCJump    <= '0;
            outALUResult <= '0;
            outALUZero   <= 1'b0;
            outRegB      <= '0;
            outRegF_wreg <= '0;
        end else if (!Debug_on) begin
            outWB        <= inWB;
            outMEM       <= inMEM;
            outPCJump    <= inPC + {inImm[29:0], 2'b00};
            outALUResult <= alu_res;
            outALUZero   <= (diff == 32'd0);
            outRegB      <= inRegB;
            outRegF_wreg <= inRegDst ? inRd : inRt;
        end
    end

    assign outStall = stall;

`ifdef EXEC_MULDIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;

    md_state_t   state;
    logic [4:0]  count;
    logic [63:0] work, work_nxt, prod;
    logic [31:0] mag_a, mag_b_in, mag_b, dividend, rem_diff;
    logic [32:0] mul_sum, rem_sh;
    logic        neg_q, neg_r;

    // Work on magnitudes; signs are restored when the last step lands in HI/LO.
    assign mag_a    = inRegA[31] ? -inRegA : inRegA;
    assign mag_b_in = op_b[31] ? -op_b : op_b;
    assign stall    = (state != IDLE);

    // MUL: shift-add, multiplier in work[31:0]. DIV: restoring, remainder work[63:32], quotient work[31:0].
    always_comb begin
        mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, mag_b} : 33'd0);
        rem_sh   = {work[63:32], work[31]};
        rem_diff = rem_sh[31:0] - mag_b;
        if (state == MUL)
            work_nxt = {mul_sum, work[31:1]};
        else if (rem_sh >= {1'b0, mag_b})
            work_nxt = {rem_diff, work[30:0], 1'b1};
        else
            work_nxt = {rem_sh[31:0], work[30:0], 1'b0};
        prod = neg_q ? -work_nxt : work_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            work     <= '0;
            mag_b    <= '0;
            dividend <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (!Debug_on) begin
            if (state == IDLE) begin
                if (inValid && is_md) begin
                    state    <= (inALUCtl == 4'hC) ? MUL : DIV;
                    count    <= '0;
                    work     <= {32'b0, mag_a};
                    mag_b    <= mag_b_in;
                    dividend <= inRegA;
                    neg_q    <= inRegA[31] ^ op_b[31];
                    neg_r    <= inRegA[31];
                end
            end else begin
                work  <= work_nxt;
                count <= count + 5'd1;
                if (count == 5'd31) begin
                    state <= IDLE;
                    if (state == MUL) begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end else if (mag_b == 32'd0) begin
                        hi <= dividend;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= neg_r ? -work_nxt[63:32] : work_nxt[63:32];
                        lo <= neg_q ? -work_nxt[31:0] : work_nxt[31:0];
                    end
                end
            end
        end
    end
`else
    assign hi    = '0;
    assign lo    = '0;
    assign stall = 1'b0;
`endif
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed table, randomized ALU traffic vs. a reference model,
// and MULT/DIV sequences (stall length, debug freeze, reset abort).
module tb_execute_stage;
    localparam bit MD_EN =
`ifdef EXEC_MULDIV_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        alusrc;
        logic        regdst;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [31:0] pc;
    } in_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [31:0] pcjump;
        logic [31:0] result;
        logic        zero;
        logic [31:0] regb;
        logic [4:0]  wreg;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic        clk, rst, inValid, inALUSrc, inRegDst, Debug_on;
    logic [1:0]  inWB, outWB;
    logic [2:0]  inMEM, outMEM;
    logic [3:0]  inALUCtl;
    logic [31:0] inPC, inRegA, inRegB, inImm;
    logic [4:0]  inRt, inRd, outRegF_wreg;
    logic [31:0] outPCJump, outALUResult, outRegB;
    logic        outALUZero, outStall;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_hi = '0, model_lo = '0;
    vec_t tbl [14];
    exp_t cur;
    in_t  rv;
    bit   dbg;

    execute_stage dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inWB(inWB), .inMEM(inMEM),
        .inALUCtl(inALUCtl), .inALUSrc(inALUSrc), .inRegDst(inRegDst), .inPC(inPC),
        .inRegA(inRegA), .inRegB(inRegB), .inImm(inImm), .inRt(inRt), .inRd(inRd),
        .Debug_on(Debug_on), .outWB(outWB), .outMEM(outMEM), .outPCJump(outPCJump),
        .outALUResult(outALUResult), .outALUZero(outALUZero), .outRegB(outRegB),
        .outRegF_wreg(outRegF_wreg), .outStall(outStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input in_t v);
        inValid  = v.valid;  inALUCtl = v.ctl;    inRegA = v.a;    inRegB = v.b;
        inImm    = v.imm;    inALUSrc = v.alusrc; inRegDst = v.regdst;
        inRt     = v.rt;     inRd     = v.rd;     inWB = v.wb;     inMEM = v.mem;
        inPC     = v.pc;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, "_wb"},     32'(outWB),        32'(e.wb));
        chk({tag, "_mem"},    32'(outMEM),       32'(e.mem));
        chk({tag, "_pcjump"}, outPCJump,         e.pcjump);
        chk({tag, "_result"}, outALUResult,      e.result);
        chk({tag, "_zero"},   32'(outALUZero),   32'(e.zero));
        chk({tag, "_regb"},   outRegB,           e.regb);
        chk({tag, "_wreg"},   32'(outRegF_wreg), 32'(e.wreg));
    endtask

    // Reference EX/MEM contents for one accepted (non-stalled, non-frozen) instruction.
    function automatic exp_t model_ex(input in_t v);
        exp_t        e;
        logic [31:0] ob;
        logic [4:0]  sh;
        longint      s;
        e = '0;
        if (!v.valid || v.ctl == 4'hC || v.ctl == 4'hD) return e;
        ob = v.alusrc ? v.imm : v.b;
        sh = v.imm[10:6];
        e.wb = v.wb;
        e.mem = v.mem;
        e.pcjump = v.pc + v.imm * 4;
        e.zero = (v.a == ob);
        e.regb = v.b;
        e.wreg = v.regdst ? v.rd : v.rt;
        case (v.ctl)
            4'h0: e.result = v.a & ob;
            4'h1: e.result = v.a | ob;
            4'h2: e.result = v.a + ob;
            4'h3: e.result = v.a ^ ob;
            4'h4: e.result = ~(v.a | ob);
            4'h6: e.result = v.a - ob;
            4'h7: e.result = ($signed(v.a) < $signed(ob)) ? 32'd1 : 32'd0;
            4'h8: e.result = ob * (32'd1 << sh);
            4'h9: e.result = ob / (32'd1 << sh);
            4'hA: begin
                s = longint'($signed(ob));
                s = s >>> sh;
                e.result = s[31:0];
            end
            4'hB: e.result = ob * 32'd65536;
            4'hE: e.result = model_hi;
            4'hF: e.result = model_lo;
            default: e.result = '0;
        endcase
        return e;
    endfunction

    task automatic md_model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q, r;
        if (ctl == 4'hC) begin
            p = longint'($signed(a)) * longint'($signed(b));
            model_hi = p[63:32];
            model_lo = p[31:0];
        end else if (b == 32'd0) begin
            model_lo = 32'hFFFF_FFFF;
            model_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            model_lo = 32'h8000_0000;
            model_hi = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            model_lo = q;
            model_hi = r;
        end
    endtask

    // Issue MULT/DIV, hold it while stalled (optionally freezing with Debug_on), then read LO and HI.
    task automatic run_md(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input int dbg_at, input int dbg_len);
        in_t v;
        int  n;
        v = '0;
        v.valid = 1'b1; v.ctl = ctl; v.a = a; v.b = b;
        v.regdst = 1'b1; v.rd = 5'd2; v.wb = 2'b11;
        drive(v);
        step();
        cmp_out("md_issue", '0);
        n = 0;
        while (outStall && n < 100) begin
            if (n == dbg_at) Debug_on = 1'b1;
            if (n == dbg_at + dbg_len) Debug_on = 1'b0;
            n++;
            step();
        end
        Debug_on = 1'b0;
        chk("md_stall_cycles", 32'(n), MD_EN ? 32'(32 + dbg_len) : 32'd0);
        if (MD_EN) md_model(ctl, a, b);
        v.ctl = 4'hF;
        drive(v);
        step();
        cmp_out("mflo", model_ex(v));
        v.ctl = 4'hE;
        drive(v);
        step();
        cmp_out("mfhi", model_ex(v));
    endtask

    initial begin
        tbl[0]  = '{'{1'b1, 4'h2, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd9, 5'd3, 2'b11, 3'b000, 32'd0},
                    '{2'b11, 3'b000, 32'd0, 32'd12, 1'b0, 32'd7, 5'd3}};
        tbl[1]  = '{'{1'b1, 4'h6, 32'h1234, 32'h1234, 32'd2, 1'b0, 1'b0, 5'd5, 5'd0, 2'b00, 3'b100, 32'h40},
                    '{2'b00, 3'b100, 32'h48, 32'd0, 1'b1, 32'h1234, 5'd5}};
        tbl[2]  = '{'{1'b1, 4'h7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd0, 5'd7, 2'b10, 3'b000, 32'h100},
                    '{2'b10, 3'b000, 32'h100, 32'd1, 1'b0, 32'd1, 5'd7}};
        tbl[3]  = '{'{1'b1, 4'hA, 32'd0, 32'h8000_0000, 32'h100, 1'b0, 1'b0, 5'd4, 5'd0, 2'b01, 3'b010, 32'd0},
                    '{2'b01, 3'b010, 32'h400, 32'hF800_0000, 1'b0, 32'h8000_0000, 5'd4}};
        tbl[4]  = '{'{1'b1, 4'h9, 32'd0, 32'h8000_0000, 32'h100, 1'b0, 1'b0, 5'd4, 5'd0, 2'b01, 3'b010, 32'd0},
                    '{2'b01, 3'b010, 32'h400, 32'h0800_0000, 1'b0, 32'h8000_0000, 5'd4}};
        tbl[5]  = '{'{1'b1, 4'h8, 32'd0, 32'd1, 32'h7C0, 1'b0, 1'b0, 5'd6, 5'd0, 2'b01, 3'b000, 32'd0},
                    '{2'b01, 3'b000, 32'h1F00, 32'h8000_0000, 1'b0, 32'd1, 5'd6}};
        tbl[6]  = '{'{1'b1, 4'hB, 32'd0, 32'd0, 32'h1234, 1'b1, 1'b1, 5'd0, 5'd8, 2'b11, 3'b000, 32'd0},
                    '{2'b11, 3'b000, 32'h48D0, 32'h1234_0000, 1'b0, 32'd0, 5'd8}};
        tbl[7]  = '{'{1'b1, 4'h4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd9, 2'b11, 3'b000, 32'h20},
                    '{2'b11, 3'b000, 32'h20, 32'hFFFF_FFFF, 1'b1, 32'd0, 5'd9}};
        tbl[8]  = '{'{1'b1, 4'h5, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 5'd10, 5'd0, 2'b11, 3'b000, 32'd0},
                    '{2'b11, 3'b000, 32'd0, 32'd0, 1'b1, 32'd3, 5'd10}};
        tbl[9]  = '{'{1'b1, 4'h2, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd0, 5'd11, 2'b11, 3'b000, 32'd0},
                    '{2'b11, 3'b000, 32'd0, 32'h8000_0000, 1'b0, 32'd1, 5'd11}};
        tbl[10] = '{'{1'b0, 4'h2, 32'd5, 32'd5, 32'd4, 1'b0, 1'b1, 5'd0, 5'd12, 2'b11, 3'b111, 32'd8},
                    '{2'b00, 3'b000, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0}};
        tbl[11] = '{'{1'b1, 4'h3, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd13, 2'b01, 3'b000, 32'd0},
                    '{2'b01, 3'b000, 32'd0, 32'hFF00, 1'b0, 32'h0FF0, 5'd13}};
        tbl[12] = '{'{1'b1, 4'h0, 32'h13, 32'h55, 32'hFFFF_FFFC, 1'b1, 1'b0, 5'd14, 5'd0, 2'b11, 3'b001, 32'd4},
                    '{2'b11, 3'b001, 32'hFFFF_FFF4, 32'h10, 1'b0, 32'h55, 5'd14}};
        tbl[13] = '{'{1'b1, 4'h1, 32'hF00, 32'h0F, 32'd0, 1'b0, 1'b1, 5'd0, 5'd31, 2'b10, 3'b010, 32'd0},
                    '{2'b10, 3'b010, 32'd0, 32'hF0F, 1'b0, 32'h0F, 5'd31}};

        rst = 1'b1;
        Debug_on = 1'b0;
        drive('0);
        step();
        step();
        cmp_out("reset", '0);
        chk("reset_stall", 32'(outStall), 32'd0);
        rst = 1'b0;

        foreach (tbl[k]) begin
            drive(tbl[k].i);
            step();
            cmp_out($sformatf("vec%0d", k), tbl[k].e);
        end

        // Freeze: a new instruction under Debug_on must not disturb EX/MEM.
        drive(tbl[0].i);
        step();
        Debug_on = 1'b1;
        drive(tbl[13].i);
        step();
        cmp_out("dbg_hold", tbl[0].e);
        Debug_on = 1'b0;
        step();
        cmp_out("dbg_release", tbl[13].e);

        cur = tbl[13].e;
        for (int k = 0; k < 300; k++) begin
            rv.valid  = ($urandom % 8) != 0;
            rv.ctl    = 4'($urandom % 16);
            if (MD_EN && (rv.ctl == 4'hC || rv.ctl == 4'hD)) rv.ctl = 4'h2;
            rv.a      = ($urandom % 4 == 0) ? 32'($urandom % 8) : $urandom;
            rv.b      = ($urandom % 4 == 0) ? rv.a : $urandom;
            rv.imm    = $urandom;
            rv.alusrc = 1'($urandom);
            rv.regdst = 1'($urandom);
            rv.rt     = 5'($urandom);
            rv.rd     = 5'($urandom);
            rv.wb     = 2'($urandom);
            rv.mem    = 3'($urandom);
            rv.pc     = $urandom;
            dbg       = ($urandom % 10) == 0;
            drive(rv);
            Debug_on = dbg;
            step();
            if (!dbg) cur = model_ex(rv);
            cmp_out("rnd", cur);
            chk("rnd_stall", 32'(outStall), 32'd0);
        end
        Debug_on = 1'b0;

        run_md(4'hC, 32'hFFFF_FFFD, 32'd7, -1, 0);
        run_md(4'hD, 32'd7, 32'd0, -1, 0);
        run_md(4'hD, 32'hFFFF_FFF9, 32'd2, -1, 0);
        run_md(4'hD, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
        run_md(4'hD, 32'hFFFF_FF9C, 32'd7, 10, 5);
        run_md(4'hD, 32'hFFFF_FF9C, 32'd7, -1, 0);
        for (int k = 0; k < 4; k++)
            run_md((k % 2 == 0) ? 4'hC : 4'hD, $urandom, $urandom, -1, 0);

        // Reset ten cycles into a MULT aborts it and clears HI/LO.
        rv = '0;
        rv.valid = 1'b1; rv.ctl = 4'hC; rv.a = 32'd1234; rv.b = 32'd5678;
        drive(rv);
        step();
        repeat (10) step();
        rst = 1'b1;
        step();
        rv.ctl = 4'hF; rv.regdst = 1'b1; rv.rd = 5'd4; rv.wb = 2'b01;
        drive(rv);
        rst = 1'b0;
        chk("rst_mid_stall", 32'(outStall), 32'd0);
        cmp_out("rst_mid", '0);
        model_hi = '0;
        model_lo = '0;
        step();
        cmp_out("rst_mflo", model_ex(rv));

        // Reset beats Debug_on.
        drive(tbl[0].i);
        step();
        Debug_on = 1'b1;
        rst = 1'b1;
        step();
        cmp_out("rst_dbg", '0);
        rst = 1'b0;
        Debug_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
